// File: rtl/regfile_pkg.sv
// Shared constants, index type and reset-value helper for the register file slice.
// Optional macro REGFILE_R0_ZERO_EN is consumed by the modules that import this package.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned NUM_REGS_DEF = 8;
  localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // Reset value of register idx: its own index, or zero when index-reset is off.
  function automatic logic [31:0] rst_val(input int unsigned idx, input logic reset_idx);
    return reset_idx ? 32'(idx) : 32'd0;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the register file: issue sets, write-back clears, sticky wr_err.
// With REGFILE_R0_ZERO_EN defined, register 0 is never tracked and never flags wr_err.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  output logic [NUM_REGS-1:0] busy_vec,
  output logic                wr_err
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                err_q, err_d;
  logic                wr_live;
  logic                iss_live;

`ifdef REGFILE_R0_ZERO_EN
  assign wr_live  = wr_en  && (wr_addr  != '0);
  assign iss_live = iss_en && (iss_addr != '0);
`else
  assign wr_live  = wr_en;
  assign iss_live = iss_en;
`endif

  // Clear before set so a same-index issue in the write-back cycle stays busy.
  always_comb begin
    busy_d = busy_q;
    err_d  = err_q;
    if (wr_live) begin
      if (!busy_q[wr_addr]) begin
        err_d = 1'b1;
      end
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_live) begin
      busy_d[iss_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign busy_vec = busy_q;
  assign wr_err   = err_q;

endmodule

// File: rtl/reg_file_sb.sv
// Parametrised register file with NUM_RD bypassing read ports and a busy scoreboard.
// Define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module reg_file_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned NUM_REGS  = NUM_REGS_DEF,
  parameter int unsigned ADDR_W    = $clog2(NUM_REGS),
  parameter int unsigned NUM_RD    = 2,
  parameter int unsigned RESET_IDX = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec,
  output logic                     wr_err
);

  logic [DATA_W-1:0] mem_q [NUM_REGS];
  logic [DATA_W-1:0] mem_d [NUM_REGS];
  logic              wr_live;

`ifdef REGFILE_R0_ZERO_EN
  assign wr_live = wr_en && (wr_addr != '0);
`else
  assign wr_live = wr_en;
`endif

  // Register 0 ignores the index-reset option when it is hardwired.
  function automatic logic [DATA_W-1:0] rst_word(input int unsigned idx);
`ifdef REGFILE_R0_ZERO_EN
    if (idx == 0) begin
      return '0;
    end
`endif
    return DATA_W'(rst_val(idx, RESET_IDX != 0));
  endfunction

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .wr_err   (wr_err)
  );

  always_comb begin
    mem_d = mem_q;
    if (wr_live) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        mem_q[ADDR_W'(i)] <= rst_word(i);
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Per-port read mux: in-flight write-back data wins over stored data and busy state.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit;

    assign ra  = rd_addr[p*ADDR_W +: ADDR_W];
    assign hit = wr_live && (wr_addr == ra);

    assign rd_data[p*DATA_W +: DATA_W] = hit ? wr_data : mem_q[ra];
    assign rd_busy[p]                  = busy_vec[ra] && !hit;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed scenarios plus randomized traffic vs. a behavioural model.
module tb_reg_file_sb;

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_RD   = 2;
`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0 = 1'b1;
`else
  localparam bit R0 = 1'b0;
`endif

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic [NUM_REGS-1:0]      busy_vec;
  logic                     wr_err;

  int checks;
  int failures;

  logic [7:0] m_mem [NUM_REGS];
  bit   [7:0] m_busy;
  bit         m_err;

  reg_file_sb #(
    .DATA_W    (DATA_W),
    .NUM_REGS  (NUM_REGS),
    .NUM_RD    (NUM_RD),
    .RESET_IDX (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .wr_err   (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit wr_hits(input int a);
    return wr_en && (int'(wr_addr) == a) && !(R0 && a == 0);
  endfunction

  function automatic logic [7:0] m_rd(input int a);
    if (wr_hits(a)) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit m_rdbusy(input int a);
    return m_busy[a] && !wr_hits(a);
  endfunction

  // Model of one clock edge, using the rules in their stated order.
  task automatic m_step();
    int wa, ia;
    wa = int'(wr_addr);
    ia = int'(iss_addr);
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) m_mem[i] = (R0 && i == 0) ? 8'd0 : 8'(i);
      m_busy = '0;
      m_err  = 1'b0;
    end else begin
      if (wr_en && !(R0 && wa == 0)) begin
        if (!m_busy[wa]) m_err = 1'b1;
        m_mem[wa]  = wr_data;
        m_busy[wa] = 1'b0;
      end
      if (iss_en && !(R0 && ia == 0)) m_busy[ia] = 1'b1;
    end
  endtask

  task automatic drive(input logic rst, input logic we, input int wa, input int wd,
                       input logic ie, input int ia, input int ra0, input int ra1);
    reset    = rst;
    wr_en    = we;
    wr_addr  = ADDR_W'(wa);
    wr_data  = DATA_W'(wd);
    iss_en   = ie;
    iss_addr = ADDR_W'(ia);
    rd_addr  = {ADDR_W'(ra1), ADDR_W'(ra0)};
    #1;
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1, 1, 3, 'h11, 1, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 3, 7);
    checks++;
    if (rd_data[7:0] !== 8'd3) begin
      failures++; $display("FAIL reset_rd3 got=%h exp=03", rd_data[7:0]);
    end
    checks++;
    if (rd_data[15:8] !== 8'd7) begin
      failures++; $display("FAIL reset_rd7 got=%h exp=07", rd_data[15:8]);
    end
    checks++;
    if (busy_vec !== 8'h00) begin
      failures++; $display("FAIL reset_busy got=%h exp=00", busy_vec);
    end
    checks++;
    if (wr_err !== 1'b0) begin
      failures++; $display("FAIL reset_wr_err got=%b exp=0", wr_err);
    end
    checks++;
    if (rd_busy !== 2'b00) begin
      failures++; $display("FAIL reset_rd_busy got=%b exp=00", rd_busy);
    end
  endtask

  task automatic test_issue_write();
    drive(0, 0, 0, 0, 1, 5, 5, 5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    checks++;
    if (busy_vec[5] !== 1'b1 || rd_busy !== 2'b11) begin
      failures++; $display("FAIL iss_busy got busy=%h rd_busy=%b exp busy[5]=1 rd_busy=11", busy_vec, rd_busy);
    end
    drive(0, 1, 5, 'hA5, 0, 0, 5, 5);
    checks++;
    if (rd_data !== 16'hA5A5 || rd_busy !== 2'b00) begin
      failures++; $display("FAIL wb_bypass got data=%h rd_busy=%b exp data=a5a5 rd_busy=00", rd_data, rd_busy);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 5, 4);
    checks++;
    if (rd_data[7:0] !== 8'hA5 || busy_vec[5] !== 1'b0 || wr_err !== 1'b0) begin
      failures++; $display("FAIL wb_commit got data=%h busy=%h err=%b exp data=a5 busy[5]=0 err=0",
                           rd_data[7:0], busy_vec, wr_err);
    end
  endtask

  task automatic test_same_cycle();
    drive(0, 0, 0, 0, 1, 2, 2, 2);
    tick();
    drive(0, 1, 2, 'h5A, 1, 2, 2, 2);
    tick();
    drive(0, 0, 0, 0, 0, 0, 2, 2);
    checks++;
    if (busy_vec[2] !== 1'b1 || rd_data[7:0] !== 8'h5A || wr_err !== 1'b0) begin
      failures++; $display("FAIL same_cycle got busy=%h data=%h err=%b exp busy[2]=1 data=5a err=0",
                           busy_vec, rd_data[7:0], wr_err);
    end
    drive(0, 1, 2, 'h66, 0, 0, 2, 2);
    tick();
  endtask

  task automatic test_wr_err();
    drive(0, 1, 4, 'h3C, 0, 0, 4, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    checks++;
    if (rd_data[15:8] !== 8'h3C || wr_err !== 1'b1) begin
      failures++; $display("FAIL wr_err_set got data=%h err=%b exp data=3c err=1", rd_data[15:8], wr_err);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1, 6, 4, 4);
      tick();
    end
    drive(0, 1, 6, 'h01, 0, 0, 4, 4);
    tick();
    checks++;
    if (wr_err !== 1'b1) begin
      failures++; $display("FAIL wr_err_sticky got=%b exp=1", wr_err);
    end
    drive(1, 0, 0, 0, 0, 0, 4, 4);
    tick();
    drive(0, 0, 0, 0, 0, 0, 4, 4);
    checks++;
    if (wr_err !== 1'b0 || rd_data[7:0] !== 8'd4) begin
      failures++; $display("FAIL wr_err_reset got err=%b data=%h exp err=0 data=04", wr_err, rd_data[7:0]);
    end
  endtask

  task automatic test_reset_mid();
    drive(0, 0, 0, 0, 1, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 1, 6, 0, 0);
    tick();
    drive(0, 1, 3, 'hEE, 0, 0, 0, 0);
    tick();
    drive(1, 1, 1, 'h77, 1, 3, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (busy_vec !== 8'h00) begin
      failures++; $display("FAIL mid_reset_busy got=%h exp=00", busy_vec);
    end
    for (int i = 0; i < NUM_REGS; i += 2) begin
      drive(0, 0, 0, 0, 0, 0, i, i + 1);
      checks++;
      if (rd_data[7:0] !== ((R0 && i == 0) ? 8'd0 : 8'(i)) || rd_data[15:8] !== 8'(i + 1)) begin
        failures++; $display("FAIL mid_reset_mem regs %0d,%0d got=%h", i, i + 1, rd_data);
      end
    end
  endtask

  task automatic test_reg0();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    tick();
    drive(0, 1, 0, 'hFF, 0, 0, 0, 1);
    checks++;
    if (rd_data[7:0] !== (R0 ? 8'h00 : 8'hFF)) begin
      failures++; $display("FAIL reg0_bypass got=%h exp=%h", rd_data[7:0], R0 ? 8'h00 : 8'hFF);
    end
    tick();
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    checks++;
    if (rd_data[7:0] !== (R0 ? 8'h00 : 8'hFF)) begin
      failures++; $display("FAIL reg0_stored got=%h exp=%h", rd_data[7:0], R0 ? 8'h00 : 8'hFF);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (busy_vec[0] !== !R0 || rd_busy[0] !== !R0) begin
      failures++; $display("FAIL reg0_busy got busy[0]=%b rd_busy=%b exp=%b", busy_vec[0], rd_busy[0], !R0);
    end
    checks++;
    if (wr_err !== m_err) begin
      failures++; $display("FAIL reg0_wr_err got=%b exp=%b", wr_err, m_err);
    end
  endtask

  task automatic test_random();
    int a;
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 47) == 0), ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
            $urandom_range(0, 255), ($urandom_range(0, 2) == 0), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 7));
      if (!reset) begin
        for (int p = 0; p < NUM_RD; p++) begin
          a = int'(rd_addr[p*ADDR_W +: ADDR_W]);
          checks++;
          if (rd_data[p*DATA_W +: DATA_W] !== m_rd(a) || rd_busy[p] !== m_rdbusy(a)) begin
            failures++;
            $display("FAIL rnd_read cyc=%0d port=%0d addr=%0d got data=%h busy=%b exp data=%h busy=%b",
                     n, p, a, rd_data[p*DATA_W +: DATA_W], rd_busy[p], m_rd(a), m_rdbusy(a));
          end
        end
      end
      tick();
      checks++;
      if (busy_vec !== m_busy || wr_err !== m_err) begin
        failures++;
        $display("FAIL rnd_state cyc=%0d got busy=%h err=%b exp busy=%h err=%b",
                 n, busy_vec, wr_err, m_busy, m_err);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_issue_write();
    test_same_cycle();
    test_wr_err();
    test_reset_mid();
    test_reg0();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised, clocked successor to the team's 8x8 register file for the pipelined datapath.
- Provides NUM_RD combinational read ports, one synchronous write port and same-cycle write-to-read bypass.
- Keeps a per-register busy scoreboard: issue sets a register's busy bit, write-back clears it.
- The hazard unit stalls on rd_busy; all state is synchronous to one clock.

Parameters:
- DATA_W, 8, register width in bits.
- NUM_REGS, 8, number of registers (power of two, >=2).
- ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override).
- NUM_RD, 2, number of independent read ports (1..4).
- RESET_IDX, 1, 1 = register i resets to value i (truncated to DATA_W); 0 = all registers reset to 0.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  read indices; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  read data per port.
- rd_busy  out  NUM_RD  per port: source register has a pending write.
- wr_en  in  1  write-back strobe.
- wr_addr  in  ADDR_W  write-back index.
- wr_data  in  DATA_W  write-back data.
- iss_en  in  1  issue strobe: mark iss_addr busy.
- iss_addr  in  ADDR_W  destination index of the issuing instruction.
- busy_vec  out  NUM_REGS  registered scoreboard, bit i = register i busy.
- wr_err  out  1  sticky flag: a write-back targeted a non-busy register.

Behaviour:
- Reset (synchronous, active-high), applied at the clk edge while reset=1:
  - mem[i] = RESET_IDX ? i : 0.
  - busy_vec = 0, wr_err = 0.
  - wr_en and iss_en are ignored during the reset cycle.
- Reset mid-operation discards all pending busy bits and data. There is no partial state.
- Write: on a clk edge with wr_en=1, mem[wr_addr] <= wr_data. Single-cycle latency.
- Read (combinational, per port p):
  - If wr_en && wr_addr==rd_addr_p, rd_data_p = wr_data (bypass).
  - Otherwise rd_data_p = mem[rd_addr_p].
- Read busy (per port p):
  - rd_busy_p = busy_vec[rd_addr_p] && !(wr_en && wr_addr==rd_addr_p).
  - A register being written back in the current cycle reads as not busy.
- Scoreboard update at each edge, applied in this order: clear first, then set.
  - wr_en clears busy[wr_addr].
  - iss_en sets busy[iss_addr].
  - Same index on both in one cycle: busy stays 1, because the new producer wins.
  - iss_en to an already-busy register: bit stays 1. No error; the scoreboard tracks the latest producer only.
- wr_err:
  - Set at the edge when wr_en=1 and busy_vec[wr_addr]==0 (before update).
  - The write itself still occurs.
  - Clears only on reset.
- Multiple read ports may address the same register. Each port is independent and returns identical values.
- No read-enable. Outputs are always driven. No X on outputs after the first reset.

Optional Feature:
- Macro REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0, regardless of RESET_IDX.
  - Writes to index 0 are discarded.
  - Bypass never applies to index 0.
  - busy[0] is never set; rd_busy for index 0 is 0.
  - wr_err is not raised for writes to 0.
- Undefined: register 0 behaves like every other register.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W_DEF=8 and NUM_REGS_DEF=8 constants.
  - typedef reg_idx_t (logic [ADDR_W-1:0] at default size).
  - function rst_val(idx, RESET_IDX).
- One sub-module, rf_scoreboard: owns busy_vec, the clear/set ordering and wr_err.
- reg_file_sb instantiates rf_scoreboard and owns the storage array, reset init and read/bypass muxes, using a generate loop over NUM_RD.

Test Plan:
- Reset with RESET_IDX=1, DATA_W=8: assert reset for 1 cycle, read ports at 3 and 7 -> rd_data=3,7; busy_vec=0; wr_err=0.
- Issue then write: iss_en addr 5 -> next cycle busy_vec[5]=1 and rd_busy for addr 5 = 1. Then wr_en addr 5, data 0xA5 in the same cycle as a read of 5 -> rd_data=0xA5 and rd_busy=0 that cycle; next cycle mem[5]=0xA5, busy_vec[5]=0.
- Simultaneous issue and write to addr 2 (busy beforehand) -> after the edge busy_vec[2]=1, mem[2]=write data, wr_err=0.
- Write to non-busy addr 4, data 0x3C -> mem[4]=0x3C, wr_err=1 and it holds until reset. Assert reset -> wr_err=0, mem[4]=4.
- Reset mid-operation: registers 1 and 6 busy, data written; assert reset -> busy_vec=0, mem[i]=i. An iss_en coinciding with reset is ignored.
- With REGFILE_R0_ZERO_EN: write 0xFF to addr 0 with a same-cycle read of 0 -> rd_data=0 that cycle and after; iss_en addr 0 -> busy_vec[0]=0.
